// File: rtl/xrv_dbus_bridge.sv
// Bridges the core's hold-until-ready data port onto a request/grant/response bus.
// One access in flight at a time, every access bounded by a timeout, failures logged.
module xrv_dbus_bridge #(
   parameter int          TIMEOUT   = 64,
   parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] d_addr,
   input  logic        d_wr_req,
   output logic        d_wr_ready,
   input  logic        d_rd_req,
   output logic        d_rd_ready,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_wr_data,
   output logic [31:0] d_rd_data,
   output logic        m_req,
   input  logic        m_gnt,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [3:0]  m_be,
   output logic [31:0] m_wdata,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata,
   input  logic        m_err,
   output logic        err_pulse,
   output logic [31:0] err_addr,
   output logic [7:0]  err_cnt
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

   state_t      r_state, w_state;
   logic [7:0]  r_timer, w_timer;
   logic        r_orphan, w_orphan;
   logic        w_req, w_we;
   logic [31:0] w_addr, w_wdata, w_rdData, w_errAddr, w_respData;
   logic [3:0]  w_be;
   logic [7:0]  w_errCnt;
   logic        w_done, w_fail;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_timer    <= 8'd0;
         r_orphan   <= 1'b0;
         m_req      <= 1'b0;
         m_we       <= 1'b0;
         m_addr     <= 32'd0;
         m_be       <= 4'd0;
         m_wdata    <= 32'd0;
         d_rd_data  <= 32'd0;
         d_wr_ready <= 1'b0;
         d_rd_ready <= 1'b0;
         err_pulse  <= 1'b0;
         err_addr   <= 32'd0;
         err_cnt    <= 8'd0;
      end else begin
         r_state    <= w_state;
         r_timer    <= w_timer;
         r_orphan   <= w_orphan;
         m_req      <= w_req;
         m_we       <= w_we;
         m_addr     <= w_addr;
         m_be       <= w_be;
         m_wdata    <= w_wdata;
         d_rd_data  <= w_rdData;
         d_wr_ready <= w_done & m_we;
         d_rd_ready <= w_done & ~m_we;
         err_pulse  <= w_done & w_fail;
         err_addr   <= w_errAddr;
         err_cnt    <= w_errCnt;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_timer    = r_timer;
      w_orphan   = r_orphan;
      w_req      = m_req;
      w_we       = m_we;
      w_addr     = m_addr;
      w_be       = m_be;
      w_wdata    = m_wdata;
      w_rdData   = d_rd_data;
      w_errAddr  = err_addr;
      w_errCnt   = err_cnt;
      w_done     = 1'b0;
      w_fail     = 1'b0;
      w_respData = ERR_RDATA;

      // A late response to a timed-out access is swallowed here, whatever the state.
      if (r_orphan && m_rvalid)
         w_orphan = 1'b0;

      case (r_state)
         IDLE: begin
            if (!r_orphan && (d_wr_req || d_rd_req)) begin
               w_addr  = d_addr;
               w_be    = d_be;
               w_wdata = d_wr_data;
               w_we    = d_wr_req;
               w_req   = 1'b1;
               w_timer = 8'd0;
               w_state = REQ;
            end else if (r_orphan && !m_rvalid) begin
               if (r_timer >= TLAST) begin
                  w_orphan = 1'b0;
                  w_timer  = 8'd0;
               end else begin
                  w_timer = r_timer + 8'd1;
               end
            end
         end
         REQ: begin
            w_timer = r_timer + 8'd1;
            if (m_gnt) begin
               w_req   = 1'b0;
               w_state = RESP;
            end else if (r_timer >= TLAST) begin
               w_req  = 1'b0;
               w_done = 1'b1;
               w_fail = 1'b1;
            end
         end
         RESP: begin
            w_timer = r_timer + 8'd1;
            if (m_rvalid) begin
               w_done = 1'b1;
               w_fail = m_err;
               if (!m_err)
                  w_respData = m_rdata;
            end else if (r_timer >= TLAST) begin
               w_done   = 1'b1;
               w_fail   = 1'b1;
               w_orphan = 1'b1;
            end
         end
         DONE: begin
            w_state = IDLE;
            w_timer = 8'd0;
         end
         default: w_state = IDLE;
      endcase

      // Completion: the ready pulse, read data and error log all land in the DONE cycle.
      if (w_done) begin
         w_state = DONE;
         if (!m_we)
            w_rdData = w_respData;
         if (w_fail) begin
            w_errAddr = m_addr;
            if (err_cnt != 8'hFF)
               w_errCnt = err_cnt + 8'd1;
         end
      end
   end

endmodule

// File: doc/xrv_dbus_bridge.md
Name: xrv_dbus_bridge

Overview:
- Sits directly downstream of the core's data port (d_*) and converts its hold-until-ready load/store handshake into a split request/grant/response memory bus.
- Registers the transaction and serialises accesses, one outstanding at a time.
- Bounds every access with a timeout so a dead target cannot hang the core.
- Reports bus errors and timeouts through a one-cycle error pulse, a captured address and a saturating counter.

Parameters:
- TIMEOUT, 64, cycles spent in REQ+RESP before the access is force-completed; legal range 2..255.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on error or timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- d_addr  in  32  core access address
- d_wr_req  in  1  core write request; held until d_wr_ready
- d_wr_ready  out  1  one-cycle write-complete pulse
- d_rd_req  in  1  core read request; held until d_rd_ready
- d_rd_ready  out  1  one-cycle read-complete pulse; d_rd_data valid in the same cycle
- d_be  in  4  byte enables
- d_wr_data  in  32  write data
- d_rd_data  out  32  read data
- m_req  out  1  bus command valid
- m_gnt  in  1  bus command accepted
- m_we  out  1  1 = write
- m_addr  out  32  bus address
- m_be  out  4  bus byte enables
- m_wdata  out  32  bus write data
- m_rvalid  in  1  response (read data or write ack)
- m_rdata  in  32  response data
- m_err  in  1  response error, qualified by m_rvalid
- err_pulse  out  1  one-cycle flag: error or timeout completed
- err_addr  out  32  address of the most recent failed access
- err_cnt  out  8  saturating failure count

Behaviour:
- All state and outputs are registered.
- Reset (rst=1 at an edge, including mid-transaction): FSM=IDLE, orphan=0.
  - m_req, d_wr_ready, d_rd_ready, err_pulse = 0; m_we = 0.
  - m_addr, m_be, m_wdata, d_rd_data, err_addr = 0; err_cnt = 0.
  - Any in-flight bus response arriving after reset is ignored.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If orphan=0 and (d_wr_req or d_rd_req): capture d_addr, d_be, d_wr_data; m_we = d_wr_req; clear the timer; go to REQ.
  - Write has priority when both requests are high. The read stays asserted by the core and is served next.
- REQ:
  - m_req = 1; timer increments each cycle.
  - m_gnt=1: m_req drops next cycle; go to RESP.
  - Timer reaches TIMEOUT-1 without gnt: drop m_req; go to DONE with fail=1.
- RESP:
  - m_req = 0; timer keeps counting.
  - m_rvalid=1: go to DONE; fail = m_err; for reads, d_rd_data = m_err ? ERR_RDATA : m_rdata.
  - Timeout: go to DONE with fail=1; set orphan=1; reads return ERR_RDATA.
- DONE (exactly one cycle):
  - Pulse d_wr_ready or d_rd_ready per m_we.
  - If fail: err_pulse=1, err_addr=m_addr, err_cnt += 1, saturating at 255.
  - Next state is IDLE.
  - The core sees ready at this edge, so the request level sampled in the following IDLE cycle belongs to the next access. Back-to-back is legal.
- Orphan:
  - While orphan=1, the next m_rvalid is discarded and clears orphan.
  - A second full TIMEOUT in IDLE also clears orphan.
  - New accesses are not issued while orphan=1.
- Latency: request seen in cycle N → m_req in N+1.
  - Minimum: gnt in N+1, rvalid in N+2, ready pulse in N+3.
  - No throughput pipelining: at most one access outstanding.
- d_rd_data holds its value until the next read completes; it is not updated by writes.
- m_rvalid in IDLE/REQ with orphan=0 is a protocol violation: discarded, no state change.
- The timer is 8 bits and never wraps, because TIMEOUT ≤ 255.

Test Plan:
- Read, zero-wait target (gnt in N+1, rvalid in N+2 with rdata=32'h1234_5678) → d_rd_ready=1 in N+3, d_rd_data=32'h1234_5678, err_pulse=0.
- d_wr_req and d_rd_req both held high, addr 0x100 → write issued first (m_we=1), d_wr_ready pulse; read issued next (m_we=0); two ready pulses, never in the same cycle.
- TIMEOUT=8, m_gnt tied low → m_req high for exactly 8 cycles; d_rd_ready=1 with d_rd_data=32'hDEAD_BEEF; err_pulse=1; err_addr=d_addr; err_cnt=1.
- Grant given, rvalid withheld past TIMEOUT, then late rvalid → timeout completion as above; orphan blocks the next request until the late rvalid, which is discarded; the following access completes normally.
- m_err=1 on a write → d_wr_ready pulse, err_pulse=1, err_cnt increments; 300 such errors → err_cnt=255.
- rst asserted while in RESP → next cycle all outputs at reset values; a subsequent read completes with normal 3-cycle latency.
